// File: rtl/led_scan_pkg.sv
// Shared display definitions: scan FSM states, dark segment value, digit count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_scan_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/led_scan_driver_scan_timer.sv
// Loadable down-counter with terminal-count flags for the scan phases.
// Latency: load takes effect on the next edge; tc reflects the current count.
// Backpressure: none; counts every cycle until it sits at zero.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        reload the counter with load_val on this edge
//   load_val    value loaded (phase length minus one)
//   tc          count is zero this cycle
//   tc_next     count will be zero next cycle (lets the parent register
//               outputs that depend on the terminal cycle)
module scan_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc,
  output logic          tc_next
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc      = (cnt_q == '0);
  assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed 7-segment scan controller with per-frame snapshot and inter-digit blanking.
// Latency: outputs registered; en/digit_n changes appear one cycle later at the earliest.
// Backpressure: none; free-running scan while en is high.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   en          scan enable; low keeps the display dark and the scan at digit 0
//   digit_n     packed active-low patterns, digit k in bits [8k+7:8k], bit 7 = dp
//   sel         one-hot active-high digit select, zero while dark
//   seg_n       active-low segments of the selected digit, all ones while dark
//   frame_done  pulse on the last lit cycle of the final digit
module led_scan_driver #(
  parameter int NUM_DIGITS   = led_scan_pkg::NUM_DIGITS,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] digit_n,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg_n,
  output logic                    frame_done
);

  import led_scan_pkg::*;

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Counter is loaded with length-1 so that cnt==0 marks the final cycle.
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam bit            HAS_BLANK  = (BLANK_CYCLES > 0);

  scan_state_e             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [8*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic                    frame_done_q, frame_done_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_load_val;
  logic          tmr_tc;
  logic          tmr_tc_next;

  scan_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tc       (tmr_tc),
    .tc_next  (tmr_tc_next)
  );

  // Next-state logic. The slot that follows a lit digit is a blank phase
  // unless blanking is configured away, in which case digits abut.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    if (!en) begin
      state_d  = IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          shadow_d     = digit_n;
          idx_d        = '0;
          tmr_load     = 1'b1;
          state_d      = HAS_BLANK ? BLANK : SHOW;
          tmr_load_val = HAS_BLANK ? BLANK_LOAD : DWELL_LOAD;
        end
        BLANK: begin
          if (tmr_tc) begin
            state_d      = SHOW;
            tmr_load     = 1'b1;
            tmr_load_val = DWELL_LOAD;
          end
        end
        SHOW: begin
          if (tmr_tc) begin
            tmr_load     = 1'b1;
            state_d      = HAS_BLANK ? BLANK : SHOW;
            tmr_load_val = HAS_BLANK ? BLANK_LOAD : DWELL_LOAD;
            if (idx_q == LAST_IDX) begin
              // Frame boundary: take the new snapshot on the same edge as the wrap.
              idx_d    = '0;
              shadow_d = digit_n;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state values so the registered outputs
  // line up cycle-for-cycle with the state registers.
  always_comb begin
    sel_d        = '0;
    seg_n_d      = SEG_OFF;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      sel_d[idx_d] = 1'b1;
      seg_n_d      = shadow_d[{idx_d, 3'b000} +: 8];
      frame_done_d = (idx_d == LAST_IDX) && tmr_tc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shadow_q     <= '1;
      sel_q        <= '0;
      seg_n_q      <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;

endmodule
